slb: RTL and testbench

Store/load buffer: the in-order memory-operation queue on the far side of the ROB's store-commit and result interfaces. Dispatch fills it with loads and stores. It snoops the EX result bus and its own result bus to resolve operand nicks. It issues the head entry to the memory controller and broadcasts completion (`iSLB_en/nick/dt` on the ROB side). Stores go to memory only after the ROB names them via the store-commit handshake.

---
 rtl/slb_pkg.sv | 68 ++++++
 rtl/slb_if.sv | 51 +++++
 rtl/slb.sv | 228 ++++++++++++++++++++++
 tb/tb_slb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slb_pkg.sv
// Store/load buffer shared definitions.
// Provides the bus widths, the memory op codes, the MC length
// encodings, the FSM state type and small op-decoding helpers used by the
// buffer and by anything that talks to it.
package slb_pkg;

  localparam int SLB_DEPTH_DEF = 16;
  localparam int NICK_W        = 5;
  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 32;

  typedef logic [NICK_W-1:0] nick_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  // Memory-controller access size: 0 = byte, 1 = half, 3 = word.
  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd3
  } slb_len_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } slb_state_e;

  function automatic logic op_is_store(op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic slb_len_e op_len(op_e op);
    slb_len_e len;
    case (op)
      OP_LB, OP_LBU, OP_SB: len = LEN_BYTE;
      OP_LH, OP_LHU, OP_SH: len = LEN_HALF;
      default:              len = LEN_WORD;
    endcase
    return len;
  endfunction

  // Sign/zero extension of the raw (zero-extended) MC load data.
  // Stores complete with 0.
  function automatic data_t load_ext(op_e op, data_t raw);
    data_t res;
    case (op)
      OP_LB:   res = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   res = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  res = {24'd0, raw[7:0]};
      OP_LHU:  res = {16'd0, raw[15:0]};
      OP_LW:   res = raw;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/slb_if.sv
// Store/load buffer bus bundle.
// Groups the dispatch, EX snoop, ROB store-commit, completion broadcast and
// memory-controller signals. The buffer uses the slave modport; the
// surrounding core (or a bench) uses the master modport.
interface slb_if
  import slb_pkg::*;
;
  logic     oSLB_full;
  logic     iDP_en;
  op_e      iDP_op;
  nick_t    iDP_qj;
  data_t    iDP_vj;
  nick_t    iDP_qk;
  data_t    iDP_vk;
  data_t    iDP_imm;
  nick_t    iDP_rd_nick;
  logic     iEX_en;
  nick_t    iEX_nick;
  data_t    iEX_dt;
  logic     iROB_store_en;
  nick_t    iROB_store_nick;
  logic     oSLB_en;
  nick_t    oSLB_nick;
  data_t    oSLB_dt;
  logic     oMC_en;
  logic     oMC_wr;
  addr_t    oMC_addr;
  data_t    oMC_dt;
  logic [1:0] oMC_len;
  logic     iMC_done;
  data_t    iMC_dt;

  modport slave (
    input  iDP_en, iDP_op, iDP_qj, iDP_vj, iDP_qk, iDP_vk, iDP_imm, iDP_rd_nick,
    input  iEX_en, iEX_nick, iEX_dt,
    input  iROB_store_en, iROB_store_nick,
    input  iMC_done, iMC_dt,
    output oSLB_full, oSLB_en, oSLB_nick, oSLB_dt,
    output oMC_en, oMC_wr, oMC_addr, oMC_dt, oMC_len
  );

  modport master (
    output iDP_en, iDP_op, iDP_qj, iDP_vj, iDP_qk, iDP_vk, iDP_imm, iDP_rd_nick,
    output iEX_en, iEX_nick, iEX_dt,
    output iROB_store_en, iROB_store_nick,
    output iMC_done, iMC_dt,
    input  oSLB_full, oSLB_en, oSLB_nick, oSLB_dt,
    input  oMC_en, oMC_wr, oMC_addr, oMC_dt, oMC_len
  );

endinterface

// File: rtl/slb.sv
// Store/load buffer: in-order memory-operation queue.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   rdy        - global enable; all state holds while low
//   iclr       - synchronous mispredict flush
//   bus        - slb_if.slave: dispatch, EX snoop, ROB store commit,
//                completion broadcast and memory-controller request
// Entries snoop both the EX bus and this block's own completion bus to
// resolve operand nicks. Only the head entry may issue; stores additionally
// wait for the ROB commit mark.
module slb
  import slb_pkg::*;
#(
  parameter int SLB_DEPTH = SLB_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic iclr,
  slb_if.slave bus
);

  localparam int PTR_W = $clog2(SLB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SLB_DEPTH);

  // Entry storage (flops: every entry is snooped every cycle)
  logic  valid_q     [SLB_DEPTH];
  logic  committed_q [SLB_DEPTH];
  op_e   op_q        [SLB_DEPTH];
  nick_t qj_q        [SLB_DEPTH];
  nick_t qk_q        [SLB_DEPTH];
  nick_t nick_q      [SLB_DEPTH];
  data_t vj_q        [SLB_DEPTH];
  data_t vk_q        [SLB_DEPTH];
  data_t imm_q       [SLB_DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  slb_state_e       state_q, state_d;

  logic     mc_en_q, mc_wr_q;
  addr_t    mc_addr_q;
  data_t    mc_dt_q;
  slb_len_e mc_len_q;
  logic     slb_en_q;
  nick_t    slb_nick_q;
  data_t    slb_dt_q;

  logic  head_ready, issue, pop, push;
  nick_t dp_qj, dp_qk;
  data_t dp_vj, dp_vk;

  // Nick 0 means "value present", so it never matches a broadcast.
  function automatic logic snoop_hit(nick_t q, logic en, nick_t n);
    return en && (q != '0) && (q == n);
  endfunction

  // Dispatch bypass: a broadcast in the dispatch cycle is captured directly.
  always_comb begin
    dp_qj = bus.iDP_qj;
    dp_vj = bus.iDP_vj;
    dp_qk = bus.iDP_qk;
    dp_vk = bus.iDP_vk;
    if (snoop_hit(bus.iDP_qj, bus.iEX_en, bus.iEX_nick)) begin
      dp_qj = '0;
      dp_vj = bus.iEX_dt;
    end else if (snoop_hit(bus.iDP_qj, slb_en_q, slb_nick_q)) begin
      dp_qj = '0;
      dp_vj = slb_dt_q;
    end
    if (snoop_hit(bus.iDP_qk, bus.iEX_en, bus.iEX_nick)) begin
      dp_qk = '0;
      dp_vk = bus.iEX_dt;
    end else if (snoop_hit(bus.iDP_qk, slb_en_q, slb_nick_q)) begin
      dp_qk = '0;
      dp_vk = slb_dt_q;
    end
  end

  // Loads only need the base; stores also need data and the ROB commit.
  assign head_ready = valid_q[head_q] && (qj_q[head_q] == '0) &&
                      (!op_is_store(op_q[head_q]) ||
                       ((qk_q[head_q] == '0) && committed_q[head_q]));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_ready) begin
          state_d = ST_WAIT;
          issue   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.iMC_done) begin
          state_d = ST_IDLE;
          pop     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A push while full is accepted only when the head pops in the same cycle.
  assign push    = bus.iDP_en && (!full_q || pop);
  assign count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_dt_q    <= '0;
      mc_len_q   <= LEN_BYTE;
      slb_en_q   <= 1'b0;
      slb_nick_q <= '0;
      slb_dt_q   <= '0;
    end else if (iclr) begin
      state_q  <= ST_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      mc_en_q  <= 1'b0;
      slb_en_q <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      head_q   <= head_q + PTR_W'(pop);
      tail_q   <= tail_q + PTR_W'(push);
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      slb_en_q <= pop;
      if (issue) begin
        mc_en_q   <= 1'b1;
        mc_wr_q   <= op_is_store(op_q[head_q]);
        mc_addr_q <= vj_q[head_q] + imm_q[head_q];
        mc_dt_q   <= vk_q[head_q];
        mc_len_q  <= op_len(op_q[head_q]);
      end
      if (pop) begin
        mc_en_q    <= 1'b0;
        slb_nick_q <= nick_q[head_q];
        slb_dt_q   <= load_ext(op_q[head_q], bus.iMC_dt);
      end
    end else begin
      // Completion is a single pulse even if rdy drops right after it.
      slb_en_q <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SLB_DEPTH; gi++) begin : g_entry
      logic wr_en, pop_en, commit_en;
      assign wr_en     = push && (tail_q == PTR_W'(gi));
      assign pop_en    = pop && (head_q == PTR_W'(gi));
      assign commit_en = bus.iROB_store_en && valid_q[gi] && op_is_store(op_q[gi]) &&
                         (nick_q[gi] == bus.iROB_store_nick);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi]     <= 1'b0;
          committed_q[gi] <= 1'b0;
          op_q[gi]        <= OP_LB;
          qj_q[gi]        <= '0;
          qk_q[gi]        <= '0;
          nick_q[gi]      <= '0;
          vj_q[gi]        <= '0;
          vk_q[gi]        <= '0;
          imm_q[gi]       <= '0;
        end else if (iclr) begin
          valid_q[gi]     <= 1'b0;
          committed_q[gi] <= 1'b0;
        end else if (rdy) begin
          if (wr_en) begin
            // Write wins over a same-slot pop when the full buffer turns over.
            valid_q[gi]     <= 1'b1;
            committed_q[gi] <= 1'b0;
            op_q[gi]        <= bus.iDP_op;
            qj_q[gi]        <= dp_qj;
            vj_q[gi]        <= dp_vj;
            qk_q[gi]        <= dp_qk;
            vk_q[gi]        <= dp_vk;
            imm_q[gi]       <= bus.iDP_imm;
            nick_q[gi]      <= bus.iDP_rd_nick;
          end else if (valid_q[gi]) begin
            if (pop_en) valid_q[gi] <= 1'b0;
            if (commit_en) committed_q[gi] <= 1'b1;
            if (snoop_hit(qj_q[gi], bus.iEX_en, bus.iEX_nick)) begin
              qj_q[gi] <= '0;
              vj_q[gi] <= bus.iEX_dt;
            end else if (snoop_hit(qj_q[gi], slb_en_q, slb_nick_q)) begin
              qj_q[gi] <= '0;
              vj_q[gi] <= slb_dt_q;
            end
            if (snoop_hit(qk_q[gi], bus.iEX_en, bus.iEX_nick)) begin
              qk_q[gi] <= '0;
              vk_q[gi] <= bus.iEX_dt;
            end else if (snoop_hit(qk_q[gi], slb_en_q, slb_nick_q)) begin
              qk_q[gi] <= '0;
              vk_q[gi] <= slb_dt_q;
            end
          end
        end
      end
    end
  endgenerate

  assign bus.oSLB_full = full_q;
  assign bus.oSLB_en   = slb_en_q;
  assign bus.oSLB_nick = slb_nick_q;
  assign bus.oSLB_dt   = slb_dt_q;
  assign bus.oMC_en    = mc_en_q;
  assign bus.oMC_wr    = mc_wr_q;
  assign bus.oMC_addr  = mc_addr_q;
  assign bus.oMC_dt    = mc_dt_q;
  assign bus.oMC_len   = mc_len_q;

endmodule

// File: tb/tb_slb.sv
// Self-checking bench for the store/load buffer. Directed scenarios plus
// randomized batches, checked against an in-order reference model that
// derives addresses, sizes and load results arithmetically.
module tb_slb;
  import slb_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, iclr;
  slb_if bus ();

  slb #(.SLB_DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .iclr (iclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_store(op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] m_len(op_e op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 32'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 32'd1;
    return 32'd3;
  endfunction

  function automatic logic [31:0] m_result(op_e op, logic [31:0] raw);
    logic [31:0] b, h;
    b = raw % 32'd256;
    h = raw % 32'd65536;
    case (op)
      OP_LB:   return (b >= 32'd128)   ? b - 32'd256   : b;
      OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
      OP_LBU:  return b;
      OP_LHU:  return h;
      OP_LW:   return raw;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_dp(input op_e op, input logic [4:0] qj, input logic [31:0] vj,
                        input logic [4:0] qk, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [4:0] nick);
    bus.iDP_en      = 1'b1;
    bus.iDP_op      = op;
    bus.iDP_qj      = qj;
    bus.iDP_vj      = vj;
    bus.iDP_qk      = qk;
    bus.iDP_vk      = vk;
    bus.iDP_imm     = imm;
    bus.iDP_rd_nick = nick;
  endtask

  task automatic dispatch(input op_e op, input logic [4:0] qj, input logic [31:0] vj,
                          input logic [4:0] qk, input logic [31:0] vk,
                          input logic [31:0] imm, input logic [4:0] nick);
    set_dp(op, qj, vj, qk, vk, imm, nick);
    step();
    bus.iDP_en = 1'b0;
  endtask

  task automatic ex_bcast(input logic [4:0] nick, input logic [31:0] dt);
    bus.iEX_en   = 1'b1;
    bus.iEX_nick = nick;
    bus.iEX_dt   = dt;
    step();
    bus.iEX_en   = 1'b0;
  endtask

  task automatic commit(input logic [4:0] nick);
    bus.iROB_store_en   = 1'b1;
    bus.iROB_store_nick = nick;
    step();
    bus.iROB_store_en   = 1'b0;
  endtask

  // Acts as the memory controller for the next in-order op.
  task automatic serve(input op_e op, input logic [4:0] nick, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] raw, input int hold);
    for (int i = 0; i < 30 && bus.oMC_en !== 1'b1; i++) step();
    chk("mc_en", bus.oMC_en, 1);
    chk("mc_addr", bus.oMC_addr, addr);
    chk("mc_wr", bus.oMC_wr, 32'(m_is_store(op)));
    chk("mc_len", bus.oMC_len, m_len(op));
    if (m_is_store(op)) chk("mc_dt", bus.oMC_dt, sdata);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("mc_hold", bus.oMC_en, 1);
    end
    bus.iMC_done = 1'b1;
    bus.iMC_dt   = raw;
    step();
    bus.iMC_done = 1'b0;
    bus.iMC_dt   = $urandom;
    chk("slb_en", bus.oSLB_en, 1);
    chk("slb_nick", bus.oSLB_nick, nick);
    chk("slb_dt", bus.oSLB_dt, m_result(op, raw));
    chk("mc_drop", bus.oMC_en, 0);
    step();
    chk("slb_pulse", bus.oSLB_en, 0);
    $display("txn op=%0d nick=%0d addr=%h raw=%h", op, nick, addr, raw);
  endtask

  // ---------------- main sequence ----------------
  op_e         f_op  [17];
  logic [31:0] f_addr[17];
  logic [31:0] f_raw [17];
  op_e         r_op  [10];
  logic [31:0] r_vj  [10];
  logic [31:0] r_imm [10];
  logic [31:0] r_sd  [10];
  logic [31:0] r_raw [10];
  bit          r_pend[10];

  initial begin
    rst = 1'b1; rdy = 1'b1; iclr = 1'b0;
    bus.iDP_en = 1'b0; bus.iDP_op = OP_LB; bus.iDP_qj = '0; bus.iDP_vj = '0;
    bus.iDP_qk = '0; bus.iDP_vk = '0; bus.iDP_imm = '0; bus.iDP_rd_nick = '0;
    bus.iEX_en = 1'b0; bus.iEX_nick = '0; bus.iEX_dt = '0;
    bus.iROB_store_en = 1'b0; bus.iROB_store_nick = '0;
    bus.iMC_done = 1'b0; bus.iMC_dt = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_mc_en", bus.oMC_en, 0);
    chk("rst_mc_wr", bus.oMC_wr, 0);
    chk("rst_mc_addr", bus.oMC_addr, 0);
    chk("rst_mc_len", bus.oMC_len, 0);
    chk("rst_mc_dt", bus.oMC_dt, 0);
    chk("rst_slb_en", bus.oSLB_en, 0);
    chk("rst_slb_nick", bus.oSLB_nick, 0);
    chk("rst_slb_dt", bus.oSLB_dt, 0);
    chk("rst_full", bus.oSLB_full, 0);

    // LW: issue latency exactly two edges after dispatch
    dispatch(OP_LW, 5'd0, 32'h1000, 5'd0, 32'h0, 32'd4, 5'd3);
    chk("lw_first_edge", bus.oMC_en, 0);
    step();
    chk("lw_second_edge", bus.oMC_en, 1);
    serve(OP_LW, 5'd3, 32'h1004, 32'h0, 32'hDEADBEEF, 0);

    // LB / LBU extension
    dispatch(OP_LB, 5'd0, 32'h10, 5'd0, 32'h0, 32'd1, 5'd4);
    serve(OP_LB, 5'd4, 32'h11, 32'h0, 32'h80, 1);
    dispatch(OP_LBU, 5'd0, 32'h10, 5'd0, 32'h0, 32'd2, 5'd5);
    serve(OP_LBU, 5'd5, 32'h12, 32'h0, 32'h80, 0);

    // Store: waits for EX data, then for the ROB commit
    dispatch(OP_SW, 5'd0, 32'h2000, 5'd5, 32'h0, 32'd8, 5'd4);
    for (int i = 0; i < 3; i++) begin step(); chk("st_wait_data", bus.oMC_en, 0); end
    ex_bcast(5'd5, 32'h55);
    for (int i = 0; i < 3; i++) begin step(); chk("st_wait_commit", bus.oMC_en, 0); end
    commit(5'd9);
    for (int i = 0; i < 3; i++) begin step(); chk("st_bad_commit", bus.oMC_en, 0); end
    commit(5'd4);
    commit(5'd4);
    serve(OP_SW, 5'd4, 32'h2008, 32'h55, 32'h12345678, 1);

    // Own completion bus resolves a later store's data
    dispatch(OP_LW, 5'd0, 32'h600, 5'd0, 32'h0, 32'd0, 5'd10);
    dispatch(OP_SH, 5'd0, 32'h700, 5'd10, 32'h0, 32'd4, 5'd11);
    serve(OP_LW, 5'd10, 32'h600, 32'h0, 32'hCAFEF00D, 0);
    commit(5'd11);
    serve(OP_SH, 5'd11, 32'h704, 32'hCAFEF00D, 32'hFFFF, 0);

    // Dispatch bypass of an EX broadcast in the same cycle
    bus.iEX_en = 1'b1; bus.iEX_nick = 5'd7; bus.iEX_dt = 32'h3000;
    dispatch(OP_LW, 5'd7, 32'hBAD0BAD0, 5'd0, 32'h0, 32'h10, 5'd12);
    bus.iEX_en = 1'b0;
    chk("byp_first_edge", bus.oMC_en, 0);
    step();
    chk("byp_second_edge", bus.oMC_en, 1);
    serve(OP_LW, 5'd12, 32'h3010, 32'h0, 32'h0BADF00D, 0);

    // rdy low holds a pending request
    dispatch(OP_LH, 5'd0, 32'h500, 5'd0, 32'h0, 32'hFFFFFFFE, 5'd6);
    step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); chk("rdy_hold", bus.oMC_en, 1); end
    rdy = 1'b1;
    serve(OP_LH, 5'd6, 32'h4FE, 32'h0, 32'h8001, 0);

    // Fill to full, turn over while full, then drain with wrap
    for (int i = 0; i < 17; i++) begin
      f_op[i]  = (i == 0 || i == 16) ? OP_LW : op_e'($urandom_range(0, 4));
      f_raw[i] = $urandom;
      f_addr[i] = (i == 0) ? 32'h100 : (i == 16) ? 32'h4000 : 32'h8000 + 32'(i * 4);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 0) dispatch(f_op[0], 5'd0, 32'h100, 5'd0, 32'h0, 32'd0, 5'd1);
      else        dispatch(f_op[i], 5'd30, 32'h0, 5'd0, 32'h0, 32'(i * 4), 5'(i + 1));
      chk("full_fill", bus.oSLB_full, 32'(i == 15));
    end
    chk("full_head_issued", bus.oMC_en, 1);
    set_dp(f_op[16], 5'd0, 32'h4000, 5'd0, 32'h0, 32'd0, 5'd17);
    bus.iMC_done = 1'b1; bus.iMC_dt = f_raw[0];
    step();
    bus.iDP_en = 1'b0; bus.iMC_done = 1'b0;
    chk("turn_slb_en", bus.oSLB_en, 1);
    chk("turn_slb_nick", bus.oSLB_nick, 1);
    chk("turn_slb_dt", bus.oSLB_dt, m_result(f_op[0], f_raw[0]));
    chk("turn_full", bus.oSLB_full, 1);
    ex_bcast(5'd30, 32'h8000);
    for (int i = 1; i < 17; i++)
      serve(f_op[i], 5'(i + 1), f_addr[i], 32'h0, f_raw[i], $urandom_range(0, 1));
    chk("drained_full", bus.oSLB_full, 0);
    for (int i = 0; i < 3; i++) begin step(); chk("drained_idle", bus.oMC_en, 0); end

    // Flush with a load in flight and two queued
    dispatch(OP_LW, 5'd0, 32'h900, 5'd0, 32'h0, 32'd0, 5'd1);
    dispatch(OP_LW, 5'd0, 32'h904, 5'd0, 32'h0, 32'd0, 5'd2);
    dispatch(OP_LW, 5'd0, 32'h908, 5'd0, 32'h0, 32'd0, 5'd3);
    chk("clr_pre_mc_en", bus.oMC_en, 1);
    iclr = 1'b1; bus.iMC_done = 1'b1; bus.iMC_dt = 32'h1;
    step();
    iclr = 1'b0; bus.iMC_done = 1'b0;
    chk("clr_mc_en", bus.oMC_en, 0);
    chk("clr_slb_en", bus.oSLB_en, 0);
    chk("clr_full", bus.oSLB_full, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("clr_empty_mc", bus.oMC_en, 0);
      chk("clr_empty_slb", bus.oSLB_en, 0);
    end
    dispatch(OP_LHU, 5'd0, 32'hA00, 5'd0, 32'h0, 32'd2, 5'd8);
    serve(OP_LHU, 5'd8, 32'hA02, 32'h0, 32'h0000F123, 0);

    // Randomized batches
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 10; i++) begin
        r_op[i]   = op_e'($urandom_range(0, 7));
        r_vj[i]   = $urandom;
        r_imm[i]  = 32'($urandom_range(0, 255)) - 32'd128;
        r_sd[i]   = $urandom;
        r_raw[i]  = $urandom;
        r_pend[i] = m_is_store(r_op[i]) && ($urandom_range(0, 1) == 1);
        if (r_pend[i])
          dispatch(r_op[i], 5'd0, r_vj[i], 5'(20 + i), $urandom, r_imm[i], 5'(i + 1));
        else
          dispatch(r_op[i], 5'd0, r_vj[i], 5'd0, r_sd[i], r_imm[i], 5'(i + 1));
      end
      for (int i = 0; i < 10; i++) begin
        if (m_is_store(r_op[i])) begin
          if (r_pend[i]) ex_bcast(5'(20 + i), r_sd[i]);
          step();
          chk("rnd_st_uncommitted", bus.oMC_en, 0);
          commit(5'(i + 1));
        end
        serve(r_op[i], 5'(i + 1), r_vj[i] + r_imm[i], r_sd[i], r_raw[i],
              $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
